// File: rtl/trace_pkg.sv
// Shared types and default widths for the PC execution tracer.
package trace_pkg;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_INSTR_W = 32;
    localparam int unsigned DEF_DEPTH   = 16;
    localparam int unsigned DEF_CYCLE_W = 16;
    localparam int unsigned DEF_PC_STEP = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Entry layout at the default widths; the tracer builds the same layout from its parameters.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] instr;
        logic                   reg_write;
        logic [DEF_CYCLE_W-1:0] stamp;
    } trace_entry_t;

    function automatic int unsigned entry_width(input int unsigned addr_w,
                                                input int unsigned instr_w,
                                                input int unsigned cycle_w);
        return addr_w + instr_w + 1 + cycle_w;
    endfunction

endpackage

// File: rtl/trace_mem.sv
// Simple dual-port trace RAM: synchronous write, registered read-before-write.
module trace_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 81
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array is deliberately left unreset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pc_trace_buffer.sv
// Execution tracer: snoops the datapath each RUN cycle into a circular buffer
// and exposes an oldest-first registered read port.
module pc_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned CYCLE_W = DEF_CYCLE_W,
    parameter int unsigned PC_STEP = DEF_PC_STEP
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic [ADDR_W-1:0]        pcQ,
    input  logic [ADDR_W-1:0]        pcD,
    input  logic [INSTR_W-1:0]       instruction,
    input  logic                     regWriteEnable,
    input  logic                     start,
    input  logic                     stopReq,
    input  logic                     captureMode,
    input  logic [CYCLE_W-1:0]       stopCount,
    input  logic [$clog2(DEPTH)-1:0] rdIndex,
    output logic [ADDR_W-1:0]        rdPc,
    output logic [INSTR_W-1:0]       rdInstr,
    output logic                     rdRegWrite,
    output logic [CYCLE_W-1:0]       rdStamp,
    output logic                     rdValid,
    output logic [CYCLE_W-1:0]       cycleCount,
    output logic [$clog2(DEPTH):0]   entryCount,
    output logic                     wrapped,
    output logic                     running,
    output logic                     done
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = entry_width(ADDR_W, INSTR_W, CYCLE_W);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               reg_write;
        logic [CYCLE_W-1:0] stamp;
    } entry_t;

    state_e             state;
    state_e             state_next;
    logic               clear;
    logic               active;
    logic               halt;
    logic               budget_hit;
    logic               qualify;
    logic               wr_en;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_addr;
    entry_t             wr_entry;
    entry_t             rd_entry;
    logic [ENTRY_W-1:0] rd_data;

    // Budget expires on the cycle whose stamp is stopCount-1; zero means unlimited.
    assign budget_hit = (stopCount != '0) && (cycleCount == stopCount - CYCLE_W'(1));
    assign qualify    = !captureMode || (pcD != pcQ + ADDR_W'(PC_STEP));
    assign wr_en      = active && qualify;

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        active     = 1'b0;
        halt       = 1'b0;
        if (start) begin
            clear      = 1'b1;
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_IDLE:   state_next = ST_IDLE;
                ST_RUN: begin
                    active = 1'b1;
                    halt   = stopReq || budget_hit;
                    if (halt) begin
                        state_next = ST_HALTED;
                    end
                end
                ST_HALTED: state_next = ST_HALTED;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == ST_RUN);
            done    <= halt;
        end
    end

    // Pointer, occupancy and cycle bookkeeping; all hold outside RUN.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_ptr     <= '0;
            cycleCount <= '0;
            entryCount <= '0;
            wrapped    <= 1'b0;
            rdValid    <= 1'b0;
        end else begin
            rdValid <= (CNT_W'(rdIndex) < entryCount);
            if (clear) begin
                wr_ptr     <= '0;
                cycleCount <= '0;
                entryCount <= '0;
                wrapped    <= 1'b0;
            end else if (active) begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    if (entryCount == CNT_W'(DEPTH)) begin
                        wrapped <= 1'b1;
                    end else begin
                        entryCount <= entryCount + CNT_W'(1);
                    end
                end
                if (cycleCount != '1) begin
                    cycleCount <= cycleCount + CYCLE_W'(1);
                end
            end
        end
    end

    // Once wrapped, the write pointer sits on the oldest surviving entry.
    assign rd_addr = (wrapped ? wr_ptr : '0) + rdIndex;

    always_comb begin
        wr_entry.pc        = pcQ;
        wr_entry.instr     = instruction;
        wr_entry.reg_write = regWriteEnable;
        wr_entry.stamp     = cycleCount;
    end

    trace_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clock   (clock),
        .resetN  (resetN),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign rd_entry   = rd_data;
    assign rdPc       = rd_entry.pc;
    assign rdInstr    = rd_entry.instr;
    assign rdRegWrite = rd_entry.reg_write;
    assign rdStamp    = rd_entry.stamp;

endmodule
